// File: rtl/shift_sched.sv
// Two-requester scheduler sharing one 16-bit barrel-style shift datapath.
// Each granted operation walks four log-stages (1,2,4,8) before presenting a held result.
module shift_sched #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] in0,
    input  logic [3:0]        cnt0,
    input  logic [1:0]        op0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [DATA_W-1:0] in1,
    input  logic [3:0]        cnt1,
    input  logic [1:0]        op1,
    output logic              gnt1,
    output logic [DATA_W-1:0] out,
    output logic              valid,
    output logic              id,
    input  logic              ack,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              id_q, id_d;
    logic              last_q, last_d;

    // One stage of the datapath: move x by 2^k in the direction/mode selected by op.
    function automatic logic [DATA_W-1:0] shift_stage(
        input logic [DATA_W-1:0] x,
        input logic [1:0]        op,
        input logic [1:0]        k
    );
        logic [2*DATA_W-1:0] dbl;
        logic [4:0]          amt;
        logic [DATA_W-1:0]   res;
        amt = 5'd1 << k;
        dbl = '0;
        case (op)
            2'b00: begin
                dbl = {x, x} << amt;
                res = dbl[2*DATA_W-1:DATA_W];
            end
            2'b01: res = x << amt;
            2'b10: begin
                dbl = {x, x} >> amt;
                res = dbl[DATA_W-1:0];
            end
            default: res = x >> amt;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        id_d    = id_q;
        last_d  = last_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (!rst) begin
                    if (req0 && (!req1 || last_q)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0) begin
                    work_d  = in0;
                    cnt_d   = cnt0;
                    op_d    = op0;
                    id_d    = 1'b0;
                    last_d  = 1'b0;
                    k_d     = 2'd0;
                    state_d = SHIFT;
                end else if (gnt1) begin
                    work_d  = in1;
                    cnt_d   = cnt1;
                    op_d    = op1;
                    id_d    = 1'b1;
                    last_d  = 1'b1;
                    k_d     = 2'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q[k_q]) begin
                    work_d = shift_stage(work_q, op_q, k_q);
                end
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            work_q  <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // Operation descriptor is only meaningful while a grant is in flight.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
        op_q  <= op_d;
    end

    assign out   = work_q;
    assign valid = (state_q == DONE);
    assign id    = id_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// Scoreboarded bench for shift_sched: a cycle model predicts grants, busy/valid and results.
module tb_shift_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, gnt0, gnt1;
    logic [15:0] in0, in1, out;
    logic [3:0]  cnt0, cnt1;
    logic [1:0]  op0, op1;
    logic        valid, id, ack, busy;

    shift_sched #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .in0(in0), .cnt0(cnt0), .op0(op0), .gnt0(gnt0),
        .req1(req1), .in1(in1), .cnt1(cnt1), .op1(op1), .gnt1(gnt1),
        .out(out), .valid(valid), .id(id), .ack(ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [15:0] res;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: apply cnt single-bit moves one after another.
    function automatic logic [15:0] ref_op(input logic [15:0] x, input logic [3:0] c, input logic [1:0] op);
        logic [15:0] v;
        v = x;
        for (int i = 0; i < int'(c); i++) begin
            case (op)
                2'b00:   v = {v[14:0], v[15]};
                2'b01:   v = {v[14:0], 1'b0};
                2'b10:   v = {v[0], v[15:1]};
                default: v = {1'b0, v[15:1]};
            endcase
        end
        return v;
    endfunction

    // Cycle model: m_st 0 = idle, 1..4 = shift cycles, 5 = done.
    int   m_st = 0;
    bit   m_on = 0;
    bit   m_last = 1;
    bit   chk_zero = 0;
    logic eg0, eg1;

    always @(negedge clk) begin
        eg0 = !rst && (m_st == 0) && req0 && (!req1 || m_last);
        eg1 = !rst && (m_st == 0) && req1 && !eg0;
        if (m_on) begin
            check("busy", busy, m_st != 0);
            check("valid", valid, m_st == 5);
            check("gnt0", gnt0, eg0);
            check("gnt1", gnt1, eg1);
            if (m_st == 0 && chk_zero) begin
                check("rst_out", out, 16'h0000);
                check("rst_id", id, 1'b0);
            end
            if (m_st == 5) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    check("out", out, sb[0].res);
                    check("id", id, sb[0].id);
                end
            end
        end
        if (rst) begin
            m_on     = 1;
            m_st     = 0;
            m_last   = 1;
            chk_zero = 1;
            sb.delete();
        end else if (m_on) begin
            if (m_st == 0) begin
                if (eg0) begin
                    sb.push_back('{id: 1'b0, res: ref_op(in0, cnt0, op0)});
                end else if (eg1) begin
                    sb.push_back('{id: 1'b1, res: ref_op(in1, cnt1, op1)});
                end
                if (eg0 || eg1) begin
                    m_last   = eg1;
                    m_st     = 1;
                    chk_zero = 0;
                end
            end else if (m_st < 5) begin
                m_st++;
            end else if (ack) begin
                void'(sb.pop_front());
                m_st = 0;
            end
        end
    end

    task automatic do_op(input bit r, input logic [15:0] x, input logic [3:0] c, input logic [1:0] o);
        @(posedge clk); #1;
        if (r) begin
            in1 = x; cnt1 = c; op1 = o; req1 = 1'b1;
        end else begin
            in0 = x; cnt0 = c; op0 = o; req0 = 1'b1;
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) check("valid_timeout", 0, 1);
    endtask

    task automatic ack_once(input bit drop);
        @(posedge clk); #1;
        ack = 1'b1;
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_op(input string tag, input bit r, input logic [15:0] x,
                          input logic [3:0] c, input logic [1:0] o, input logic [15:0] exp);
        int n;
        do_op(r, x, c, o);
        wait_valid(n);
        check({tag, "_lat"}, n, 5);
        check({tag, "_out"}, out, exp);
        check({tag, "_id"}, id, r);
        ack_once(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; ack = 1'b0;
        req0 = 1'b0; in0 = '0; cnt0 = '0; op0 = '0;
        req1 = 1'b0; in1 = '0; cnt1 = '0; op1 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_out", out, 16'h0000);

        run_op("s1_srl", 1'b0, 16'h8001, 4'd4, 2'b11, 16'h0800);
        run_op("s2_rol", 1'b1, 16'h8001, 4'd1, 2'b00, 16'h0003);
        run_op("s2_ror", 1'b1, 16'h1234, 4'd15, 2'b10, 16'h2468);
        run_op("s4_sll0", 1'b0, 16'hFFFF, 4'd0, 2'b01, 16'hFFFF);
        run_op("s4_sll15", 1'b0, 16'hFFFF, 4'd15, 2'b01, 16'h8000);

        // Ties from reset alternate 0,1,0,1.
        apply_reset();
        @(posedge clk); #1;
        in0 = 16'h00F0; cnt0 = 4'd3; op0 = 2'b00;
        in1 = 16'h0F00; cnt1 = 4'd5; op1 = 2'b10;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            check("s3_id", id, i % 2);
            ack_once(i == 3);
        end

        // Held result while ack stays low and requester 0 churns.
        do_op(1'b0, 16'hA5C3, 4'd9, 2'b10);
        wait_valid(n);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in0  = 16'($urandom);
            cnt0 = 4'($urandom);
            req0 = ~req0;
        end
        req0 = 1'b0;
        ack_once(1'b0);
        @(negedge clk);
        check("s5_valid_after_ack", valid, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] x;
            logic [3:0]  c;
            logic [1:0]  o;
            x = 16'($urandom);
            c = 4'($urandom);
            o = 2'($urandom);
            run_op("rand", 1'($urandom), x, c, o, ref_op(x, c, o));
        end

        // Reset during stage 2 of an op from requester 0 with a tie pending.
        run_op("s6_pre", 1'b0, 16'h0101, 4'd2, 2'b01, 16'h0404);
        @(posedge clk); #1;
        in0 = 16'h7E81; cnt0 = 4'd7; op0 = 2'b00; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        in1 = 16'h1111; cnt1 = 4'd1; op1 = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("s6_valid", valid, 1'b0);
        check("s6_busy", busy, 1'b0);
        check("s6_out", out, 16'h0000);
        check("s6_gnt0", gnt0, 1'b1);
        check("s6_gnt1", gnt1, 1'b0);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        wait_valid(n);
        check("s6_id", id, 1'b0);
        check("s6_res", out, ref_op(16'h7E81, 4'd7, 2'b00));
        ack_once(1'b0);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 wants a shift
- in0  input  16  requester 0 operand
- cnt0  input  4  requester 0 shift amount (0-15)
- op0  input  2  requester 0 operation
- gnt0  output  1  requester 0 operands captured this cycle
- req1, in1, cnt1, op1, gnt1  same widths and meanings, requester 1
- out  output  16  shift result
- valid  output  1  out/id hold a completed result
- id  output  1  requester that owns the result (0 or 1)
- ack  input  1  consumer accepts the result
- busy  output  1  high in any state other than IDLE
REQ-002 The reset SHALL be synchronous and active-high on port rst, sampled on the rising edge of clk; clk SHALL be the only clock.
REQ-003 Op encoding SHALL be: 00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical.

Function
REQ-004 The block SHALL own one shared 16-bit shift datapath and run one operation at a time through a 3-state FSM: IDLE, SHIFT, DONE.
REQ-005 In IDLE with neither request high, the state SHALL remain IDLE and both grants SHALL stay low.
REQ-006 In IDLE with exactly one request high, that requester's grant SHALL go high combinationally for that cycle. On the next edge, its in/cnt/op SHALL be latched, id SHALL be set to its index, the stage counter SHALL be cleared to 0, and the state SHALL move to SHIFT.
REQ-007 In IDLE with both requests high, the grant SHALL go to the requester not granted most recently (round-robin). The last-granted pointer SHALL update only when a grant is issued.
REQ-008 At most one grant SHALL be high in any cycle, and grants SHALL be low outside IDLE.
REQ-009 Requests SHALL be level-sensitive. A requester not granted keeps req high, and this block SHALL NOT queue requests.
REQ-010 In SHIFT, the stage counter k (2 bits) SHALL run 0,1,2,3, one stage per cycle. At stage k the working register SHALL be shifted or rotated by 2^k positions if latched cnt[k]=1, and SHALL be held if cnt[k]=0.
REQ-011 Logical shifts SHALL fill vacated bits with 0. Rotates SHALL wrap bits end-around. All arithmetic SHALL be 16-bit, with no carry out.
REQ-012 After stage 3, the state SHALL move to DONE. Every operation, including cnt=0, SHALL take exactly 4 SHIFT cycles.
REQ-013 Latency SHALL be as follows: grant in cycle T, SHIFT in cycles T+1 to T+4, valid high from cycle T+5.
REQ-014 In DONE, valid SHALL be 1, and out and id SHALL be held stable until ack is sampled high.
REQ-015 In DONE with ack=1, the state SHALL return to IDLE on that edge, and valid SHALL be 0 the following cycle.
REQ-016 Requests arriving in DONE SHALL be ignored until IDLE. A new grant SHALL occur no earlier than the cycle after ack.
REQ-017 ack SHALL be ignored outside DONE.
REQ-018 Input changes on in/cnt/op after their grant SHALL NOT affect the operation in flight.
REQ-019 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.

Reset
REQ-020 With rst=1 at a clock edge, the FSM SHALL go to IDLE and the stage counter SHALL be set to 0.
REQ-021 With rst=1 at a clock edge, out SHALL be 0x0000, valid=0, id=0 and busy=0.
REQ-022 With rst=1 at a clock edge, the last-granted pointer SHALL be set to 1, so requester 0 wins the first tie.
REQ-023 Grants SHALL be 0 while rst=1.
REQ-024 A reset in SHIFT or DONE SHALL abort the operation with no result delivered, and the requester SHALL re-request.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Scenario 1: req0 only, in0=0x8001, cnt0=4, op0=11 (SRL) -> gnt0 at T; valid=1, out=0x0800, id=0 at T+5.
- Scenario 2: req1 only, in1=0x8001, cnt1=1, op1=00 (ROL) -> out=0x0003, id=1. With in1=0x1234, cnt1=15, op1=10 (ROR) -> out=0x2468.
- Scenario 3: req0 and req1 held high from reset, ack returned one cycle after each valid -> grants alternate 0,1,0,1. Results are tagged with the matching id. No grant occurs while busy=1.
- Scenario 4: cnt=0 and cnt=15 with op=01, in=0xFFFF -> 0xFFFF and 0x8000. Each still reaches valid exactly 5 cycles after the grant.
- Scenario 5: hold ack=0 for 10 cycles in DONE while toggling in0/req0 -> out, id and valid stay stable. Ack then gives valid=0 the next cycle.
- Scenario 6: assert rst during stage 2 of SHIFT -> next cycle valid=0, busy=0, out=0x0000. A pending tie is then granted to requester 0.
